// File: rtl/solomon_snd_pkg.sv
// Shared definitions for the Solomon's Key main-to-sound command channel.
package solomon_snd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } nmi_state_t;

    localparam int NMI_LEN_DEF = 16;
    localparam int NMI_GAP_DEF = 32;
    localparam int IRQ_DIV_DEF = 25000;

endpackage

// File: rtl/solomon_sound_cmd_sndfifo.sv
// Command byte FIFO; a pop and a push in the same cycle keep the count, even when full.
module SNDFIFO #(
    parameter int DEPTH = 2
) (
    input  logic                     CPUCL,
    input  logic                     RESET_N,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_nxt,
    output logic                     empty,
    output logic                     do_pop,
    output logic                     ovf_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          full, do_push;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    // The pop frees a slot first, so a full FIFO still accepts a same-cycle push.
    assign do_push  = push & (~full | do_pop);
    assign ovf_drop = push & full & ~do_pop;
    assign dout     = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (do_pop && !do_push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge CPUCL) begin
        if (!RESET_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    always_ff @(posedge CPUCL) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/solomon_sound_cmd.sv
// Main-to-sound command channel: strobe edge detect, command FIFO, NMI sequencer, IRQ divider.
module solomon_sound_cmd
    import solomon_snd_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int NMI_LEN = NMI_LEN_DEF,
    parameter int NMI_GAP = NMI_GAP_DEF,
    parameter int IRQ_DIV = IRQ_DIV_DEF
) (
    input  logic       CPUCL,
    input  logic       RESET_N,
    input  logic       SNDWR,
    input  logic [7:0] CPUWD,
    input  logic       SNDRD,
    input  logic       SCEN,
    input  logic       SIRQACK,
    output logic [7:0] SNDDT,
    output logic       SNMI,
    output logic       SIRQ,
    output logic       EMPTY,
    output logic       OVF
);
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int TMAX = (NMI_LEN > NMI_GAP) ? NMI_LEN : NMI_GAP;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int DW   = (IRQ_DIV > 1) ? $clog2(IRQ_DIV) : 1;

    logic          psndwr, psndrd, push, pop;
    logic [7:0]    head, last;
    logic [CW-1:0] count, count_nxt;
    logic          do_pop, ovf_drop;

    nmi_state_t    state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          pop_pend, pop_pend_nxt;
    logic [DW-1:0] div;
    logic          wrap;

    assign push = SNDWR & ~psndwr;
    assign pop  = ~SNDRD & psndrd;

    SNDFIFO #(.DEPTH(DEPTH)) u_fifo (
        .CPUCL     (CPUCL),
        .RESET_N   (RESET_N),
        .push      (push),
        .pop       (pop),
        .din       (CPUWD),
        .dout      (head),
        .count     (count),
        .count_nxt (count_nxt),
        .empty     (EMPTY),
        .do_pop    (do_pop),
        .ovf_drop  (ovf_drop)
    );

    // Strobe history clears in reset so a strobe held through release reads as a new edge.
    always_ff @(posedge CPUCL) begin
        if (!RESET_N) begin
            psndwr <= 1'b0;
            psndrd <= 1'b0;
            last   <= 8'h00;
            OVF    <= 1'b0;
        end else begin
            psndwr <= SNDWR;
            psndrd <= SNDRD;
            if (do_pop)
                last <= head;
            if (ovf_drop)
                OVF <= 1'b1;
        end
    end

    assign SNDDT = EMPTY ? last : head;

    always_ff @(posedge CPUCL) begin
        if (!RESET_N) begin
            state    <= IDLE;
            timer    <= '0;
            pop_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            pop_pend <= pop_pend_nxt;
        end
    end

    // A pop seen while pulsing is held so WAIT can leave on its first cycle.
    assign pop_pend_nxt = (state == PULSE) & (pop_pend | do_pop);

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nxt = PULSE;
                    timer_nxt = TW'(NMI_LEN - 1);
                end
            end
            PULSE: begin
                if (timer == '0)
                    state_nxt = WAIT;
                else
                    timer_nxt = timer - 1'b1;
            end
            WAIT: begin
                if (do_pop || pop_pend) begin
                    if (count_nxt != '0) begin
                        state_nxt = GAP;
                        timer_nxt = TW'(NMI_GAP - 1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                if (timer == '0) begin
                    if (count != '0) begin
                        state_nxt = PULSE;
                        timer_nxt = TW'(NMI_LEN - 1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign SNMI = (state == PULSE);

    assign wrap = SCEN & (div == DW'(IRQ_DIV - 1));

    // A fresh request outranks an acknowledge landing in the same cycle.
    always_ff @(posedge CPUCL) begin
        if (!RESET_N) begin
            div  <= '0;
            SIRQ <= 1'b0;
        end else begin
            if (SCEN)
                div <= wrap ? '0 : div + 1'b1;
            if (wrap)
                SIRQ <= 1'b1;
            else if (SIRQACK)
                SIRQ <= 1'b0;
        end
    end

endmodule

// File: tb/tb_solomon_sound_cmd.sv
// Directed bench for solomon_sound_cmd (DEPTH=2, NMI_LEN=16, NMI_GAP=32, IRQ_DIV=4).
module tb_solomon_sound_cmd;

    logic       CPUCL = 1'b0;
    logic       RESET_N = 1'b0;
    logic       SNDWR = 1'b0;
    logic [7:0] CPUWD = 8'h00;
    logic       SNDRD = 1'b0;
    logic       SCEN = 1'b0;
    logic       SIRQACK = 1'b0;
    logic [7:0] SNDDT;
    logic       SNMI, SIRQ, EMPTY, OVF;

    int n_chk  = 0;
    int n_fail = 0;
    int hi;

    solomon_sound_cmd #(
        .DEPTH(2), .NMI_LEN(16), .NMI_GAP(32), .IRQ_DIV(4)
    ) dut (
        .CPUCL   (CPUCL),
        .RESET_N (RESET_N),
        .SNDWR   (SNDWR),
        .CPUWD   (CPUWD),
        .SNDRD   (SNDRD),
        .SCEN    (SCEN),
        .SIRQACK (SIRQACK),
        .SNDDT   (SNDDT),
        .SNMI    (SNMI),
        .SIRQ    (SIRQ),
        .EMPTY   (EMPTY),
        .OVF     (OVF)
    );

    always #5 CPUCL = ~CPUCL;

    task automatic tick();
        @(posedge CPUCL);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        SNDWR = 1'b1;
        CPUWD = b;
        tick();
        SNDWR = 1'b0;
        tick();
    endtask

    task automatic read_byte();
        SNDRD = 1'b1;
        tick();
        SNDRD = 1'b0;
        tick();
    endtask

    task automatic wait_nmi_low(input string tag);
        for (int i = 0; i < 40 && SNMI; i++)
            tick();
        chk(tag, SNMI, 1'b0);
    endtask

    initial begin
        do_reset();
        chk("rst_snddt", SNDDT, 8'h00);
        chk("rst_snmi", SNMI, 1'b0);
        chk("rst_sirq", SIRQ, 1'b0);
        chk("rst_empty", EMPTY, 1'b1);
        chk("rst_ovf", OVF, 1'b0);
        tick();

        // single command, 16-cycle NMI starting one edge after the write
        SNDWR = 1'b1;
        CPUWD = 8'h5A;
        tick();
        SNDWR = 1'b0;
        chk("wr_empty", EMPTY, 1'b0);
        chk("wr_snddt", SNDDT, 8'h5A);
        chk("wr_snmi_k", SNMI, 1'b0);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            hi += int'(SNMI);
        end
        chk("nmi_len", hi, 16);
        tick();
        chk("nmi_end", SNMI, 1'b0);

        // read of the only entry: empty, byte held, no further NMI
        read_byte();
        chk("rd_empty", EMPTY, 1'b1);
        chk("rd_hold", SNDDT, 8'h5A);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            hi += int'(SNMI);
        end
        chk("idle_no_nmi", hi, 0);

        // overflow with DEPTH=2, then NMI gap after first pop
        write_byte(8'h01);
        write_byte(8'h02);
        chk("ovf_clear", OVF, 1'b0);
        SNDWR = 1'b1;
        CPUWD = 8'h03;
        tick();
        SNDWR = 1'b0;
        chk("ovf_set", OVF, 1'b1);
        chk("ovf_head", SNDDT, 8'h01);
        wait_nmi_low("nmi1_fall");
        read_byte();
        chk("pop1_data", SNDDT, 8'h02);
        chk("pop1_empty", EMPTY, 1'b0);
        hi = 0;
        for (int i = 0; i < 31; i++) begin
            tick();
            hi += int'(SNMI);
        end
        chk("gap_low", hi, 0);
        tick();
        chk("gap_rise", SNMI, 1'b1);
        wait_nmi_low("nmi2_fall");
        read_byte();
        chk("pop2_data", SNDDT, 8'h02);
        chk("pop2_empty", EMPTY, 1'b1);
        chk("ovf_sticky", OVF, 1'b1);

        // full FIFO, push and pop in the same cycle
        do_reset();
        tick();
        write_byte(8'hA1);
        write_byte(8'hA2);
        chk("full_head", SNDDT, 8'hA1);
        SNDRD = 1'b1;
        tick();
        SNDWR = 1'b1;
        CPUWD = 8'hC3;
        SNDRD = 1'b0;
        tick();
        SNDWR = 1'b0;
        chk("simul_ovf", OVF, 1'b0);
        chk("simul_head", SNDDT, 8'hA2);
        chk("simul_empty", EMPTY, 1'b0);
        read_byte();
        chk("simul_rd1", SNDDT, 8'hC3);
        chk("simul_rd1_empty", EMPTY, 1'b0);
        read_byte();
        chk("simul_rd2", SNDDT, 8'hC3);
        chk("simul_rd2_empty", EMPTY, 1'b1);

        // IRQ divider with SCEN held high
        do_reset();
        SCEN = 1'b1;
        tick();
        tick();
        tick();
        chk("irq_tick3", SIRQ, 1'b0);
        tick();
        chk("irq_tick4", SIRQ, 1'b1);
        SIRQACK = 1'b1;
        tick();
        SIRQACK = 1'b0;
        chk("irq_ack", SIRQ, 1'b0);
        tick();
        tick();
        chk("irq_tick7", SIRQ, 1'b0);
        SIRQACK = 1'b1;
        tick();
        SIRQACK = 1'b0;
        SCEN = 1'b0;
        chk("irq_ack_wrap", SIRQ, 1'b1);
        tick();
        chk("irq_hold", SIRQ, 1'b1);

        // reset mid-PULSE with SNDWR held high
        write_byte(8'h11);
        write_byte(8'h22);
        SNDWR = 1'b1;
        CPUWD = 8'h33;
        tick();
        SNDWR = 1'b0;
        chk("pre_rst_ovf", OVF, 1'b1);
        tick();
        chk("pre_rst_snmi", SNMI, 1'b1);
        SNDWR = 1'b1;
        CPUWD = 8'h77;
        RESET_N = 1'b0;
        tick();
        chk("mid_rst_snmi", SNMI, 1'b0);
        chk("mid_rst_empty", EMPTY, 1'b1);
        chk("mid_rst_snddt", SNDDT, 8'h00);
        chk("mid_rst_ovf", OVF, 1'b0);
        chk("mid_rst_sirq", SIRQ, 1'b0);
        tick();
        RESET_N = 1'b1;
        tick();
        chk("rel_push_empty", EMPTY, 1'b0);
        chk("rel_push_data", SNDDT, 8'h77);
        tick();
        chk("rel_snmi", SNMI, 1'b1);
        read_byte();
        chk("pulse_pop_empty", EMPTY, 1'b1);
        chk("pulse_pop_data", SNDDT, 8'h77);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            hi += int'(SNMI);
        end
        chk("pulse_pop_rest", hi, 13);
        chk("held_no_repush", EMPTY, 1'b1);
        SNDWR = 1'b0;
        tick();
        SNDWR = 1'b1;
        CPUWD = 8'h88;
        tick();
        SNDWR = 1'b0;
        tick();
        chk("idle_after_pend", SNMI, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
